// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit CPU sequencer: state encoding,
// opcode values and the bit positions of the instruction fields.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ALU_WAIT,
    S_WB,
    S_HALT,
    S_FAULT
  } state_e;

  // Opcode values in IR[15:12]; unlisted opcodes execute as NOP.
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'h7;
  localparam logic [3:0] OP_JMP    = 4'h8;
  localparam logic [3:0] OP_JZ     = 4'h9;
  localparam logic [3:0] OP_HALT   = 4'hF;

  // Instruction field positions.
  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int ALUOP_MSB = 14;
  localparam int ALUOP_LSB = 12;
  localparam int TGT_MSB   = 11;
  localparam int TGT_LSB   = 7;

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational opcode classifier for the sequencer's instruction register.
module cpu_seq_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic        is_alu,
  output logic        is_jmp,
  output logic        is_jz,
  output logic        is_halt
);

  logic [3:0] opc;
  logic       unused_ir;

  assign opc = ir[OPC_MSB:OPC_LSB];

  // Only the opcode steers control; operand and target bits pass through IR.
  assign unused_ir = ^{ir[TGT_MSB:TGT_LSB], ir[TGT_LSB-1:0]};

  assign is_alu  = (opc >= OP_ALU_LO) && (opc <= OP_ALU_HI);
  assign is_jmp  = (opc == OP_JMP);
  assign is_jz   = (opc == OP_JZ);
  assign is_halt = (opc == OP_HALT);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute via ALU handshake, then
// advance or jump the PC. Outputs are flops loaded from the next state and
// next IR, so each pulse is glitch-free and aligned with its state.
// Optional ALU watchdog: define CPU_SEQ_WATCHDOG_EN to enable the FAULT path.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  pc,
  output logic [4:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  output logic        pc_done,
  output logic        pc_jmp,
  output logic [15:0] pc_instr,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  input  logic        alu_done,
  input  logic        alu_zero,
  output logic        rf_we,
  output logic        busy,
  output logic        halted,
  output logic        fault
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        zf_q, zf_d;
  logic        pc_done_q, pc_done_d;
  logic        pc_jmp_q, pc_jmp_d;
  logic        alu_start_q, alu_start_d;
  logic        rf_we_q, rf_we_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;
  logic        is_alu, is_jmp, is_jz, is_halt;
  logic        take_jmp;

  // Decode the next IR: it equals the current IR everywhere except DECODE,
  // where it is the word being latched, which is what EXEC outputs need.
  cpu_seq_decode u_dec (
    .ir      (ir_d),
    .is_alu  (is_alu),
    .is_jmp  (is_jmp),
    .is_jz   (is_jz),
    .is_halt (is_halt)
  );

`ifdef CPU_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            fault_q, fault_d;
  logic            wd_expire;

  // Counter is zero on ALU_WAIT entry and counts each cycle spent there.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == S_ALU_WAIT) wd_cnt_d = wd_cnt_q + 1'b1;
  end

  // Expires on the cycle the count would reach TIMEOUT.
  assign wd_expire = (wd_cnt_q == WD_LAST);
`else
  logic unused_timeout;
  logic wd_expire;
  assign unused_timeout = (TIMEOUT > 0);
  assign wd_expire      = 1'b0;
`endif

  assign take_jmp = is_jmp || (is_jz && zf_d);

  // Next-state, IR and zero-flag logic plus the registered-output decode.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    zf_d    = zf_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = imem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_alu)       state_d = S_ALU_WAIT;
        else if (is_halt) state_d = S_HALT;
        else              state_d = S_WB;
      end
      S_ALU_WAIT: begin
        // alu_done takes priority over a watchdog expiry in the same cycle.
        if (alu_done) begin
          zf_d    = alu_zero;
          state_d = S_WB;
        end else if (wd_expire) begin
          state_d = S_FAULT;
        end
      end
      S_WB:       state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_IDLE;
    endcase

    alu_start_d = (state_d == S_EXEC) && is_alu;
    rf_we_d     = (state_d == S_WB) && is_alu;
    pc_jmp_d    = (state_d == S_WB) && take_jmp;
    pc_done_d   = (state_d == S_WB) && !take_jmp;
    busy_d      = (state_d != S_IDLE) && (state_d != S_HALT) && (state_d != S_FAULT);
    halted_d    = (state_d == S_HALT);
  end

`ifdef CPU_SEQ_WATCHDOG_EN
  assign fault_d = (state_d == S_FAULT);
`endif

  // State, IR, flag and output registers; reset drops to IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      zf_q        <= 1'b0;
      pc_done_q   <= 1'b0;
      pc_jmp_q    <= 1'b0;
      alu_start_q <= 1'b0;
      rf_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
`ifdef CPU_SEQ_WATCHDOG_EN
      wd_cnt_q    <= '0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      zf_q        <= zf_d;
      pc_done_q   <= pc_done_d;
      pc_jmp_q    <= pc_jmp_d;
      alu_start_q <= alu_start_d;
      rf_we_q     <= rf_we_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
`ifdef CPU_SEQ_WATCHDOG_EN
      wd_cnt_q    <= wd_cnt_d;
      fault_q     <= fault_d;
`endif
    end
  end

  assign imem_addr = pc;
  assign pc_instr  = ir_q;
  assign alu_op    = ir_q[ALUOP_MSB:ALUOP_LSB];
  assign pc_done   = pc_done_q;
  assign pc_jmp    = pc_jmp_q;
  assign alu_start = alu_start_q;
  assign rf_we     = rf_we_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
`ifdef CPU_SEQ_WATCHDOG_EN
  assign fault     = fault_q;
`else
  assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: models the PC, instruction memory and a
// fixed-latency ALU; expected pulses are queued by the stimulus and popped
// by a monitor whenever the sequencer emits one.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  pc;
  logic [4:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        pc_done, pc_jmp, alu_start, rf_we, busy, halted, fault;
  logic [15:0] pc_instr;
  logic [2:0]  alu_op;
  logic        alu_done, alu_zero;

  cpu_sequencer #(.TIMEOUT(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pc         (pc),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .pc_done    (pc_done),
    .pc_jmp     (pc_jmp),
    .pc_instr   (pc_instr),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_done   (alu_done),
    .alu_zero   (alu_zero),
    .rf_we      (rf_we),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory, synchronous read.
  logic [15:0] mem [32];
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  // Program counter block.
  always @(posedge clk or posedge rst) begin
    if (rst)         pc <= 5'd0;
    else if (pc_jmp) pc <= pc_instr[11:7];
    else if (pc_done) pc <= pc + 5'd1;
  end

  // ALU: done is raised alu_dly cycles into ALU_WAIT; 0 withholds it.
  int   alu_dly = 0;
  logic alu_z = 1'b0;
  int   alu_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst)            alu_cnt <= 0;
    else if (alu_start) alu_cnt <= alu_dly;
    else if (alu_cnt > 0) alu_cnt <= alu_cnt - 1;
  end
  assign alu_done = (alu_cnt == 1);
  assign alu_zero = alu_done ? alu_z : 1'b0;

  typedef struct {
    logic       done;
    logic       jmp;
    logic       we;
    int         gap;
    logic [4:0] tgt;
  } exp_t;

  exp_t       pq[$];
  logic [2:0] aq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int last_cyc = 0;
  exp_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic d, input logic j, input logic w, input int g, input logic [4:0] t);
    exp_t x;
    x.done = d; x.jmp = j; x.we = w; x.gap = g; x.tgt = t;
    pq.push_back(x);
  endtask

  // Monitor: every pulse must match the head of the matching queue.
  always @(negedge clk) begin
    if (alu_start) begin
      if (aq.size() == 0) chk("unexpected alu_start", 32'(alu_start), 32'd0);
      else                chk("alu_op", 32'(alu_op), 32'(aq.pop_front()));
    end
    if (pc_done || pc_jmp || rf_we) begin
      if (pq.size() == 0) begin
        chk("unexpected pc/rf pulse", 32'({pc_done, pc_jmp, rf_we}), 32'd0);
      end else begin
        e = pq.pop_front();
        chk("pulse kind {done,jmp,we}", 32'({pc_done, pc_jmp, rf_we}), 32'({e.done, e.jmp, e.we}));
        chk("instr latency", 32'(cyc - last_cyc), 32'(e.gap));
        if (e.jmp) chk("jump target", 32'(pc_instr[11:7]), 32'(e.tgt));
        last_cyc = cyc;
      end
    end
  end

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 32; i++) mem[i] = v;
  endtask

  // Pulse start from IDLE; the cycle after the sampling edge is FETCH.
  task automatic go();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #1 last_cyc = cyc - 1;
    start = 1'b0;
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc && (pq.size() + aq.size()) != 0; i++) begin
      @(negedge clk); #1;
    end
    chk("pending expected pulses", 32'(pq.size() + aq.size()), 32'd0);
  endtask

  task automatic chk_idle_outs(input string name);
    chk(name, 32'({pc_done, pc_jmp, alu_start, rf_we, busy, halted, fault}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    #1 chk_idle_outs("outputs in reset");
    @(posedge clk); #2 rst = 1'b0;
  endtask

  initial begin
    int seen;
    fill(16'h0000);

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outs("reset outputs");
    chk("reset pc_instr", 32'(pc_instr), 32'd0);
    chk("reset alu_op", 32'(alu_op), 32'd0);
    chk("reset imem_addr", 32'(imem_addr), 32'd0);
    @(posedge clk); #2 rst = 1'b0;

    // Idle without start.
    seen = 0;
    repeat (10) begin @(negedge clk); seen += int'(busy); end
    chk("busy while idle", 32'(seen), 32'd0);

    // NOP stream with PC wrap.
    for (int i = 0; i < 2; i++) push(1, 0, 0, 4, 0);
    go();
    drain(20);
    @(posedge clk); #1 chk("pc after 2 nops", 32'(pc), 32'd2);
    for (int i = 0; i < 30; i++) push(1, 0, 0, 4, 0);
    drain(200);
    @(posedge clk); #1 chk("pc wrap 31->0", 32'(pc), 32'd0);
    do_reset();

    // ALU op, then HALT with start toggling.
    fill(16'hF000);
    mem[0] = 16'h1234;
    alu_dly = 3; alu_z = 1'b0;
    aq.push_back(3'd1);
    push(1, 0, 1, 7, 0);
    go();
    drain(30);
    repeat (6) @(negedge clk);
    chk("halted after 0xF000", 32'(halted), 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2 start = ~start;
      @(negedge clk); seen += int'(pc_done || pc_jmp || rf_we || alu_start);
    end
    start = 1'b0;
    chk("pulses while halted", 32'(seen), 32'd0);
    chk("halt is terminal {halted,busy}", 32'({halted, busy}), 32'b10);
    do_reset();

    // JMP 0x8A00 to 20.
    fill(16'hF000);
    mem[0] = 16'h8A00;
    push(0, 1, 0, 4, 20);
    go();
    drain(20);
    @(posedge clk); #1 chk("imem_addr after jmp", 32'(imem_addr), 32'd20);
    do_reset();

    // JZ taken after ALU zero result.
    fill(16'hF000);
    mem[0] = 16'h1000; mem[1] = 16'h9500;
    alu_dly = 1; alu_z = 1'b1;
    aq.push_back(3'd1);
    push(1, 0, 1, 5, 0);
    push(0, 1, 0, 4, 10);
    go();
    drain(40);
    @(posedge clk); #1 chk("pc after jz taken", 32'(pc), 32'd10);
    do_reset();

    // JZ not taken after ALU non-zero result.
    fill(16'hF000);
    mem[0] = 16'h2000; mem[1] = 16'h9500;
    alu_dly = 2; alu_z = 1'b0;
    aq.push_back(3'd2);
    push(1, 0, 1, 6, 0);
    push(1, 0, 0, 4, 0);
    go();
    drain(40);
    @(posedge clk); #1 chk("pc after jz not taken", 32'(pc), 32'd2);
    do_reset();

    // JZ right after reset (zf cleared) and an undefined opcode as NOP.
    fill(16'hF000);
    mem[0] = 16'h9500; mem[1] = 16'hA123;
    push(1, 0, 0, 4, 0);
    push(1, 0, 0, 4, 0);
    go();
    drain(40);
    @(posedge clk); #1 chk("pc after jz/undef", 32'(pc), 32'd2);
    do_reset();

    // Reset while waiting on the ALU.
    fill(16'hF000);
    mem[0] = 16'h3000;
    alu_dly = 0;
    aq.push_back(3'd3);
    go();
    repeat (6) @(posedge clk);
    #2 chk("busy in alu_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    #1 chk_idle_outs("async reset in alu_wait");
    @(posedge clk); #2 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle after reset", 32'({busy, halted}), 32'd0);

`ifdef CPU_SEQ_WATCHDOG_EN
    // Watchdog: ALU never answers.
    mem[0] = 16'h4000;
    aq.push_back(3'd4);
    go();
    seen = 0;
    for (int i = 0; i < 200 && !fault; i++) @(negedge clk);
    chk("fault raised", 32'(fault), 32'd1);
    chk("fault cycle from fetch", 32'(cyc - (last_cyc + 1)), 32'd67);
    chk("fault state outputs {busy,halted}", 32'({busy, halted}), 32'd0);
    do_reset();
`endif

    drain(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control FSM for the 16-bit processor. Each instruction is fetched from the 32-entry instruction memory at the current program-counter value, decoded, and run through the ALU via a start/done handshake. The block then tells the program counter to advance or jump. It drives the program counter's `done`/`JMP`/`instr` inputs and the register-file write enable, and it is the only block that changes the program counter after reset.

## Interface
Parameters:
- `TIMEOUT`, default 64: ALU watchdog limit in cycles. Used only with `CPU_SEQ_WATCHDOG_EN`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: leave IDLE and begin fetching.
- `pc` in 5: current program-counter value.
- `imem_addr` out 5: instruction memory address. Synchronous read, 1-cycle latency.
- `imem_rdata` in 16: instruction memory data.
- `pc_done` out 1: one-cycle pulse to the PC, meaning increment.
- `pc_jmp` out 1: one-cycle pulse to the PC, meaning load `pc_instr[11:7]`.
- `pc_instr` out 16: instruction register (IR).
- `alu_start` out 1: one-cycle pulse that starts an ALU operation.
- `alu_op` out 3: ALU operation code, equal to `IR[14:12]`.
- `alu_done` in 1: ALU completion, sampled only in ALU_WAIT.
- `alu_zero` in 1: ALU zero result, captured when `alu_done` is high.
- `rf_we` out 1: one-cycle register-file write strobe.
- `busy` out 1: high in every state except IDLE, HALT and FAULT.
- `halted` out 1: high in HALT.
- `fault` out 1: high in FAULT; tied to 0 without the macro.

## Operation
- Opcode field is `IR[15:12]`:
  - 0x0 NOP.
  - 0x1–0x7 ALU ops.
  - 0x8 JMP.
  - 0x9 JZ.
  - 0xF HALT.
  - All other values execute as NOP.
- States: IDLE, FETCH, DECODE, EXEC, ALU_WAIT, WB, HALT, FAULT.
- IDLE: go to FETCH when `start` is high; stay otherwise.
- FETCH: `imem_addr` = `pc`; go to DECODE.
- DECODE: IR <= `imem_rdata`; go to EXEC.
- EXEC:
  - ALU op: pulse `alu_start` and go to ALU_WAIT.
  - HALT: go to HALT.
  - Anything else: go to WB.
- ALU_WAIT:
  - Wait for `alu_done`.
  - On `alu_done`, capture `alu_zero` into the zero flag `zf` and go to WB.
  - `alu_done` seen in EXEC is ignored.
- WB, exactly one PC pulse:
  - ALU op: `rf_we`=1 and `pc_done`=1.
  - JMP: `pc_jmp`=1.
  - JZ: `pc_jmp`=1 if `zf`=1, else `pc_done`=1.
  - NOP: `pc_done`=1.
  - After WB, go to FETCH.
- `pc_done` and `pc_jmp` are never asserted together.
- HALT is terminal: no PC pulses, `start` ignored, exit only by reset.
- JMP/JZ do not modify `zf`. NOP does not modify `zf`.
- PC wrap from 31 to 0 is handled by the PC block; the sequencer needs no special case.

## Timing
- Reset values:
  - state = IDLE; IR = 0; `zf` = 0.
  - All outputs 0, except `imem_addr`, which follows `pc`.
- Reset asserted mid-instruction returns to IDLE on the same edge. No further pulses are issued.
- Outputs are registered per state, i.e. decoded from the state register plus IR.
- Instruction latency:
  - NOP/JMP/JZ: 4 cycles (FETCH, DECODE, EXEC, WB).
  - ALU op: 4 + N cycles, where N ≥ 1 is the number of ALU_WAIT cycles including the one in which `alu_done` is seen.
- The PC updates on the edge that ends WB, so the following FETCH presents the new `pc`.

## Configuration
- `CPU_SEQ_WATCHDOG_EN` defined:
  - A counter of `$clog2(TIMEOUT+1)` bits clears on entry to ALU_WAIT and increments each ALU_WAIT cycle.
  - If the count reaches `TIMEOUT` without `alu_done`, go to FAULT. FAULT is terminal, `fault`=1, and there are no PC or `rf_we` pulses.
  - If `alu_done` arrives on the same cycle the limit is reached, `alu_done` wins.
- Undefined: no counter, ALU_WAIT waits indefinitely, `fault` is tied to 0.

## Structure
- Package `cpu_pkg` holds:
  - the state enum;
  - opcode constants (OP_NOP, OP_JMP, OP_JZ, OP_HALT, ALU range);
  - field-slice constants for the opcode and the jump target `[11:7]`.
- One sub-module, `cpu_seq_decode`: combinational, takes IR and produces `is_alu`, `is_jmp`, `is_jz`, `is_halt`.

## Test plan
- Reset/start:
  - Hold `rst`: all outputs 0 and state IDLE.
  - Release `rst` with `start`=0 for 10 cycles: `busy`=0 throughout.
- NOP stream:
  - Memory all 0x0000, `start` pulse.
  - `pc_done` pulses every 4th cycle; the PC model goes 0→1→2, and wraps 31→0.
- ALU op 0x1234 with `alu_done` 3 cycles after `alu_start`:
  - Exactly one `alu_start`; `alu_op`=1.
  - `rf_we` and `pc_done` pulse together in WB, 7 cycles after FETCH.
- JMP 0x8A00 (target 20):
  - `pc_jmp` pulses once; `pc_instr[11:7]`=20; `pc_done` stays low; the next `imem_addr` is 20.
- JZ 0x9500 (target 10):
  - Following an ALU op that returns `alu_zero`=1: jumps to 10.
  - Following an ALU op that returns `alu_zero`=0: `pc_done` instead.
- Halt, reset and watchdog:
  - 0xF000: `halted`=1 and no further pulses for 20 cycles, even with `start` toggled.
  - Reset asserted during ALU_WAIT: IDLE immediately.
  - With the macro and `alu_done` withheld: `fault`=1 after exactly 64 ALU_WAIT cycles.
